// File: rtl/shift_exec_stage_pkg.sv
// Shared definitions for the KGP_miniRISC execute-stage shift unit.
// Covers funct codes, shifter drive encodings and skid-buffer occupancy states.
package kgp_defs;

  localparam int unsigned KGP_DATA_W  = 32;
  localparam int unsigned KGP_SHAMT_W = 5;
  localparam int unsigned KGP_REG_W   = 5;

  localparam logic [2:0] F_SHLL  = 3'b000;
  localparam logic [2:0] F_SHRL  = 3'b001;
  localparam logic [2:0] F_SHRA  = 3'b010;
  localparam logic [2:0] F_SHLLV = 3'b100;
  localparam logic [2:0] F_SHRLV = 3'b101;
  localparam logic [2:0] F_SHRAV = 3'b110;

  typedef enum logic {
    DRXN_LEFT  = 1'b0,
    DRXN_RIGHT = 1'b1
  } drxn_e;

  typedef enum logic {
    TYPE_LOGIC = 1'b0,
    TYPE_ARITH = 1'b1
  } shtype_e;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  // One buffered result: shifted value, destination tag, illegal-op flag
  typedef struct packed {
    logic [KGP_DATA_W-1:0] data;
    logic [KGP_REG_W-1:0]  rd;
    logic                  ill;
  } res_t;

endpackage

// File: rtl/shift_exec_stage_if.sv
// ID->EX->MEM handshake bundle for the shift execute stage.
// slave is the stage's view; master is the surrounding pipeline's view.
interface shift_exec_stage_if;

  logic                                in_valid;
  logic                                in_ready;
  logic [2:0]                          in_funct;
  logic [kgp_defs::KGP_DATA_W-1:0]     in_rs;
  logic [kgp_defs::KGP_DATA_W-1:0]     in_rt;
  logic [kgp_defs::KGP_SHAMT_W-1:0]    in_shamt;
  logic [kgp_defs::KGP_REG_W-1:0]      in_rd;
  logic                                out_valid;
  logic                                out_ready;
  logic [kgp_defs::KGP_DATA_W-1:0]     out_data;
  logic [kgp_defs::KGP_REG_W-1:0]      out_rd;
  logic                                out_ill;

  modport slave (
    input  in_valid, in_funct, in_rs, in_rt, in_shamt, in_rd, out_ready,
    output in_ready, out_valid, out_data, out_rd, out_ill
  );

  modport master (
    output in_valid, in_funct, in_rs, in_rt, in_shamt, in_rd, out_ready,
    input  in_ready, out_valid, out_data, out_rd, out_ill
  );

endinterface

// File: rtl/shift_exec_stage_shifter.sv
// Combinational 32-bit barrel shifter: left/right, logical/arithmetic.
// Amount 0 passes A through unchanged in every mode.
module shifter
  import kgp_defs::*;
(
  input  logic [KGP_DATA_W-1:0]  A,
  input  logic [KGP_SHAMT_W-1:0] shamt,
  input  drxn_e                  drxn,
  input  shtype_e                typ,
  output logic [KGP_DATA_W-1:0]  out
);

  always_comb begin
    out = A;
    if (drxn == DRXN_LEFT) begin
      out = A << shamt;
    end else if (typ == TYPE_ARITH) begin
      out = $unsigned($signed(A) >>> shamt);
    end else begin
      out = A >> shamt;
    end
  end

endmodule

// File: rtl/shift_exec_stage.sv
// Execute-stage shift unit: decodes the shift op, shifts on the accept cycle and
// buffers results in a 2-entry skid (main drives outputs, skid sits behind it).
module shift_exec_stage
  import kgp_defs::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  shift_exec_stage_if.slave  bus
);

  if (DATA_W != 32 || SHAMT_W != 5) begin : g_bad_param
    $error("shift_exec_stage supports only DATA_W=32, SHAMT_W=5");
  end

  state_e             r_state;
  state_e             w_state_nx;
  logic               r_in_ready;
  res_t               r_main;
  res_t               r_skid;
  res_t               w_new;

  logic               w_accept;
  logic               w_drain;
  logic               w_ld_main_in;
  logic               w_ld_main_skid;
  logic               w_ld_skid;

  logic               w_legal;
  drxn_e              w_drxn;
  shtype_e            w_type;
  logic [SHAMT_W-1:0] w_amt;
  logic [DATA_W-1:0]  w_shift_out;
  logic               w_unused_rt;

  assign w_unused_rt = ^bus.in_rt[DATA_W-1:SHAMT_W];

  // funct[2] picks the amount source; funct[1:0] picks the shift kind
  always_comb begin
    w_legal = 1'b1;
    w_drxn  = DRXN_LEFT;
    w_type  = TYPE_LOGIC;
    w_amt   = bus.in_shamt;
    case (bus.in_funct)
      F_SHLL:  ;
      F_SHRL:  w_drxn = DRXN_RIGHT;
      F_SHRA:  begin w_drxn = DRXN_RIGHT; w_type = TYPE_ARITH; end
      F_SHLLV: w_amt = bus.in_rt[SHAMT_W-1:0];
      F_SHRLV: begin w_drxn = DRXN_RIGHT; w_amt = bus.in_rt[SHAMT_W-1:0]; end
      F_SHRAV: begin
        w_drxn = DRXN_RIGHT;
        w_type = TYPE_ARITH;
        w_amt  = bus.in_rt[SHAMT_W-1:0];
      end
      default: w_legal = 1'b0;
    endcase
  end

  shifter u_shifter (
    .A     (bus.in_rs),
    .shamt (w_amt),
    .drxn  (w_drxn),
    .typ   (w_type),
    .out   (w_shift_out)
  );

  always_comb begin
    w_new.data = w_legal ? w_shift_out : '0;
    w_new.rd   = bus.in_rd;
    w_new.ill  = ~w_legal;
  end

  assign bus.out_valid = (r_state != S_EMPTY);
  assign bus.in_ready  = r_in_ready;
  assign bus.out_data  = r_main.data;
  assign bus.out_rd    = r_main.rd;
  assign bus.out_ill   = r_main.ill;

  assign w_accept = bus.in_valid & r_in_ready & ~flush;
  assign w_drain  = bus.out_valid & bus.out_ready;

  always_comb begin
    w_state_nx     = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          w_state_nx   = S_ONE;
          w_ld_main_in = 1'b1;
        end
      end
      S_ONE: begin
        if (w_accept && !w_drain) begin
          w_state_nx = S_FULL;
          w_ld_skid  = 1'b1;
        end else if (w_accept && w_drain) begin
          w_ld_main_in = 1'b1;
        end else if (w_drain) begin
          w_state_nx = S_EMPTY;
        end
      end
      S_FULL: begin
        if (w_drain) begin
          w_state_nx     = S_ONE;
          w_ld_main_skid = 1'b1;
        end
      end
      default: w_state_nx = S_EMPTY;
    endcase
    if (flush) begin
      w_state_nx     = S_EMPTY;
      w_ld_main_in   = 1'b0;
      w_ld_main_skid = 1'b0;
      w_ld_skid      = 1'b0;
    end
  end

  // in_ready is registered from the next state so it never depends on in_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
      r_main     <= '0;
      r_skid     <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_in_ready <= (w_state_nx != S_FULL);
      if (w_ld_main_in) begin
        r_main <= w_new;
      end else if (w_ld_main_skid) begin
        r_main <= r_skid;
      end
      if (w_ld_skid) begin
        r_skid <= w_new;
      end
    end
  end

endmodule

// File: tb/tb_shift_exec_stage.sv
// Directed bench for shift_exec_stage: inputs driven and outputs sampled on the falling edge.
module tb_shift_exec_stage;
  import kgp_defs::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  shift_exec_stage_if bus ();

  shift_exec_stage #(.DATA_W(32), .SHAMT_W(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus.slave)
  );

  // {in_ready, out_valid, out_ill, out_rd, out_data}
  function automatic logic [39:0] obs();
    return {bus.in_ready, bus.out_valid, bus.out_ill, bus.out_rd, bus.out_data};
  endfunction

  function automatic logic [39:0] mk(input logic rdy, input logic vld, input logic ill,
                                     input logic [4:0] rd, input logic [31:0] data);
    return {rdy, vld, ill, rd, data};
  endfunction

  task automatic set_op(input logic [2:0] f, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [4:0] sh, input logic [4:0] rd);
    bus.in_valid = 1'b1;
    bus.in_funct = f;
    bus.in_rs    = rs;
    bus.in_rt    = rt;
    bus.in_shamt = sh;
    bus.in_rd    = rd;
  endtask

  task automatic test_reset();
    logic [39:0] got, exp;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    got = obs(); exp = mk(1, 0, 0, 0, 32'h0);
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL reset got=%h exp=%h", got, exp); end
    rst = 1'b0;
  endtask

  task automatic test_shra();
    logic [39:0] got, exp;
    bus.out_ready = 1'b1;
    set_op(F_SHRA, 32'h8000_0000, 32'h0, 5'd3, 5'd7);
    @(negedge clk);
    bus.in_valid = 1'b0;
    got = obs(); exp = mk(1, 1, 0, 5'd7, 32'hF000_0000);
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL shra got=%h exp=%h", got, exp); end
    @(negedge clk);
    got = obs();
    vectors++;
    if (got[39:38] !== 2'b10) begin miscompares++; $display("FAIL shra_drained got=%b exp=10", got[39:38]); end
  endtask

  task automatic test_modes();
    logic [39:0] got, exp;
    bus.out_ready = 1'b1;
    set_op(F_SHRLV, 32'h8000_0000, 32'h0000_0023, 5'd0, 5'd1);
    @(negedge clk);
    got = obs(); exp = mk(1, 1, 0, 5'd1, 32'h1000_0000);
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL shrlv got=%h exp=%h", got, exp); end
    set_op(F_SHLL, 32'h0000_0001, 32'h0, 5'd31, 5'd2);
    @(negedge clk);
    got = obs(); exp = mk(1, 1, 0, 5'd2, 32'h8000_0000);
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL shll31 got=%h exp=%h", got, exp); end
    set_op(F_SHRL, 32'hA5A5_0F0F, 32'h0, 5'd0, 5'd3);
    @(negedge clk);
    got = obs(); exp = mk(1, 1, 0, 5'd3, 32'hA5A5_0F0F);
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL shrl0 got=%h exp=%h", got, exp); end
    set_op(F_SHRAV, 32'h8000_0001, 32'hFFFF_FFFF, 5'd0, 5'd4);
    @(negedge clk);
    got = obs(); exp = mk(1, 1, 0, 5'd4, 32'hFFFF_FFFF);
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL shrav31 got=%h exp=%h", got, exp); end
    set_op(F_SHLLV, 32'h0000_00FF, 32'h0000_0004, 5'd9, 5'd5);
    @(negedge clk);
    got = obs(); exp = mk(1, 1, 0, 5'd5, 32'h0000_0FF0);
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL shllv got=%h exp=%h", got, exp); end
    set_op(F_SHRA, 32'h7FFF_FFFF, 32'h0, 5'd4, 5'd6);
    @(negedge clk);
    got = obs(); exp = mk(1, 1, 0, 5'd6, 32'h07FF_FFFF);
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL shra_pos got=%h exp=%h", got, exp); end
    bus.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [39:0] got, exp;
    bus.out_ready = 1'b0;
    set_op(F_SHLL, 32'h0000_0001, 32'h0, 5'd4, 5'd1);
    @(negedge clk);
    got = obs(); exp = mk(1, 1, 0, 5'd1, 32'h0000_0010);
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL b2b_first got=%h exp=%h", got, exp); end
    set_op(F_SHRL, 32'hF000_0000, 32'h0, 5'd8, 5'd2);
    @(negedge clk);
    got = obs(); exp = mk(0, 1, 0, 5'd1, 32'h0000_0010);
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL b2b_full got=%h exp=%h", got, exp); end
    set_op(F_SHRA, 32'h8000_0000, 32'h0, 5'd31, 5'd3);
    @(negedge clk);
    got = obs(); exp = mk(0, 1, 0, 5'd1, 32'h0000_0010);
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL b2b_hold got=%h exp=%h", got, exp); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    got = obs(); exp = mk(1, 1, 0, 5'd2, 32'h00F0_0000);
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL b2b_second got=%h exp=%h", got, exp); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    got = obs(); exp = mk(1, 1, 0, 5'd3, 32'hFFFF_FFFF);
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL b2b_third got=%h exp=%h", got, exp); end
    @(negedge clk);
    got = obs();
    vectors++;
    if (got[39:38] !== 2'b10) begin miscompares++; $display("FAIL b2b_empty got=%b exp=10", got[39:38]); end
  endtask

  task automatic test_flush();
    logic [39:0] got, exp;
    bus.out_ready = 1'b0;
    set_op(F_SHLL, 32'h0000_0001, 32'h0, 5'd4, 5'd1);
    @(negedge clk);
    set_op(F_SHLL, 32'h0000_0001, 32'h0, 5'd5, 5'd2);
    @(negedge clk);
    got = obs(); exp = mk(0, 1, 0, 5'd1, 32'h0000_0010);
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL flush_prefull got=%h exp=%h", got, exp); end
    flush = 1'b1;
    set_op(F_SHLL, 32'h0000_0001, 32'h0, 5'd6, 5'd3);
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      got = obs();
      vectors++;
      if (got[39:38] !== 2'b10) begin miscompares++; $display("FAIL flush_full_%0d got=%b exp=10", i, got[39:38]); end
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    set_op(F_SHLL, 32'h0000_0001, 32'h0, 5'd4, 5'd1);
    @(negedge clk);
    flush = 1'b1;
    set_op(F_SHLL, 32'h0000_0001, 32'h0, 5'd8, 5'd8);
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    got = obs();
    vectors++;
    if (got[39:38] !== 2'b10) begin miscompares++; $display("FAIL flush_one got=%b exp=10", got[39:38]); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    got = obs();
    vectors++;
    if (got[39:38] !== 2'b10) begin miscompares++; $display("FAIL flush_no_stale got=%b exp=10", got[39:38]); end
    set_op(F_SHRL, 32'h0000_0100, 32'h0, 5'd4, 5'd10);
    @(negedge clk);
    bus.in_valid = 1'b0;
    got = obs(); exp = mk(1, 1, 0, 5'd10, 32'h0000_0010);
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL flush_after got=%h exp=%h", got, exp); end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    logic [39:0] got, exp;
    bus.out_ready = 1'b1;
    set_op(3'b011, 32'hFFFF_FFFF, 32'h0, 5'd1, 5'd9);
    @(negedge clk);
    got = obs(); exp = mk(1, 1, 1, 5'd9, 32'h0);
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL ill_011 got=%h exp=%h", got, exp); end
    set_op(3'b111, 32'h0000_1234, 32'h0000_0002, 5'd0, 5'd11);
    @(negedge clk);
    got = obs(); exp = mk(1, 1, 1, 5'd11, 32'h0);
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL ill_111 got=%h exp=%h", got, exp); end
    set_op(F_SHLL, 32'h0000_0003, 32'h0, 5'd1, 5'd12);
    @(negedge clk);
    bus.in_valid = 1'b0;
    got = obs(); exp = mk(1, 1, 0, 5'd12, 32'h0000_0006);
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL ill_next_legal got=%h exp=%h", got, exp); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [39:0] got, exp;
    bus.out_ready = 1'b0;
    set_op(F_SHLL, 32'h0000_0001, 32'h0, 5'd2, 5'd1);
    @(negedge clk);
    set_op(F_SHLL, 32'h0000_0001, 32'h0, 5'd3, 5'd2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    got = obs(); exp = mk(1, 0, 0, 5'd0, 32'h0);
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL reset_mid got=%h exp=%h", got, exp); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    got = obs();
    vectors++;
    if (got[39:38] !== 2'b10) begin miscompares++; $display("FAIL reset_mid_drop got=%b exp=10", got[39:38]); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_funct = 3'b000;
    bus.in_rs = '0;
    bus.in_rt = '0;
    bus.in_shamt = '0;
    bus.in_rd = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_shra();
    test_modes();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
